// File: rtl/store_merge_rmw.sv
// store_merge_rmw: multi-cycle read-modify-write store unit merging sub-word stores into memory words
module store_merge_rmw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              done,
    output logic              err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        op_q;
    logic              err_q;
    logic [OFF_W-1:0]  req_off, off;
    logic              misaligned, full_width;
    logic [BYTES-1:0]  lanes;
    logic [DATA_W-1:0] shifted, merged;

    assign req_off   = req_addr[OFF_W-1:0];
    assign off       = addr_q[OFF_W-1:0];
    assign req_ready = state == IDLE;
    assign mem_rd_en = state == READ;
    assign mem_wr_en = state == WRITE;
    assign done      = state == FIN;
    assign err       = done && err_q;
    assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // classify the incoming request: rejected, full-width (no read needed) or sub-word
    always_comb begin
        misaligned = (req_op == 2'b01 && req_off[0]) ||
                     (req_op == 2'b10 && req_off[1:0] != 2'b00) ||
                     (req_op == 2'b11 && (DATA_W == 32 || req_off != '0));
        full_width = !misaligned && (DATA_W == 32 ? req_op == 2'b10 : req_op == 2'b11);
    end

    // overlay the latched store bytes onto the old word at the byte lanes it covers
    always_comb begin
        lanes   = (op_q == 2'b00 ? BYTES'(1) : op_q == 2'b01 ? BYTES'(3) : BYTES'(15)) << off;
        shifted = data_q << {off, 3'b000};
        merged  = mem_rd_data;
        for (int i = 0; i < BYTES; i++)
            merged[8*i +: 8] = lanes[i] ? shifted[8*i +: 8] : mem_rd_data[8*i +: 8];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = misaligned ? FIN : full_width ? WRITE : READ;
            READ:    state_nxt = WAIT;
            WAIT:    if (mem_rd_valid) state_nxt = WRITE;
            WRITE:   if (mem_wr_ready) state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // request latch and registered write data (full-width data at accept, merged word on read return)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= '0;
            err_q       <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
                data_q <= req_data;
                op_q   <= req_op;
                err_q  <= misaligned;
                if (full_width) mem_wr_data <= req_data;
            end
            if (state == WAIT && mem_rd_valid) mem_wr_data <= merged;
        end
    end
endmodule
